// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller turning a 2**W-entry register file into a FWFT FIFO.
module fifo_ctrl #(
  parameter int W      = 2,
  parameter int AF_LVL = 2**W-1,
  parameter int AE_LVL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr_err,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);
  localparam logic [W:0] DEPTH = (W+1)'(2**W);
  logic wa, ra;
  // flags come only from the registered count, never from wr/rd
  assign full         = count == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = count >= (W+1)'(AF_LVL);
  assign almost_empty = count <= (W+1)'(AE_LVL);
  assign wa           = wr & ~full;
  assign ra           = rd & ~empty;
  assign wr_en        = wa & rst_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr    <= '0;
      r_addr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      w_addr    <= w_addr + W'(wa);
      r_addr    <= r_addr + W'(ra);
      count     <= count + (W+1)'(wa) - (W+1)'(ra);
      overflow  <= (overflow & ~clr_err) | (wr & full);
      underflow <= (underflow & ~clr_err) | (rd & empty);
    end
  end
endmodule
